// File: rtl/oflow_iou_pkg.sv
// Shared types and defaults for the optical-flow IoU engine.
// Box packing is {X_TL, Y_TL, X_BR, Y_BR}, with X_TL in the most significant field.
package oflow_iou_pkg;

    localparam int COORD_W_DEF = 11;
    localparam int FRAC_W_DEF  = 11;

    typedef enum logic [2:0] {
        IDLE,
        INTER,
        UNION,
        DIV,
        DONE
    } iou_state_t;

    typedef struct packed {
        logic [COORD_W_DEF-1:0] x_tl;
        logic [COORD_W_DEF-1:0] y_tl;
        logic [COORD_W_DEF-1:0] x_br;
        logic [COORD_W_DEF-1:0] y_br;
    } bbox_t;

    function automatic bbox_t bbox_unpack(input logic [4*COORD_W_DEF-1:0] v);
        bbox_t b;
        b.x_tl = v[4*COORD_W_DEF-1 -: COORD_W_DEF];
        b.y_tl = v[3*COORD_W_DEF-1 -: COORD_W_DEF];
        b.x_br = v[2*COORD_W_DEF-1 -: COORD_W_DEF];
        b.y_br = v[1*COORD_W_DEF-1 -: COORD_W_DEF];
        return b;
    endfunction

endpackage

// File: rtl/oflow_iou_div.sv
// Sequential restoring divider producing FRAC_W fraction bits of num/den.
// The caller guarantees num < den, so the quotient is purely fractional.
module oflow_iou_div
    import oflow_iou_pkg::*;
#(
    parameter int NUM_W  = 22,
    parameter int DEN_W  = 23,
    parameter int FRAC_W = FRAC_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [NUM_W-1:0]  num,
    input  logic [DEN_W-1:0]  den,
    output logic              busy,
    output logic              done,
    output logic [FRAC_W-1:0] quot
);

    localparam int CW = $clog2(FRAC_W + 1);

    logic              busy_q, busy_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DEN_W-1:0]  rem_q, rem_d;
    logic [DEN_W-1:0]  den_q, den_d;
    logic [FRAC_W-2:0] quo_q, quo_d;

    logic [DEN_W:0]    rem_shift;
    logic              take;
    logic [DEN_W-1:0]  rem_next;

    // The shifted remainder is kept one bit wider so the compare never wraps.
    assign rem_shift = {rem_q, 1'b0};
    assign take      = (rem_shift >= {1'b0, den_q});
    assign rem_next  = take ? DEN_W'(rem_shift - {1'b0, den_q}) : DEN_W'(rem_shift);
    assign quot      = {quo_q, take};
    assign busy      = busy_q;
    assign done      = busy_q && (cnt_q == CW'(1));

    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        rem_d  = rem_q;
        den_d  = den_q;
        quo_d  = quo_q;
        if (start) begin
            busy_d = 1'b1;
            cnt_d  = CW'(FRAC_W);
            rem_d  = DEN_W'(num);
            den_d  = den;
            quo_d  = '0;
        end else if (busy_q) begin
            rem_d = rem_next;
            quo_d = quot[FRAC_W-2:0];
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            rem_q  <= '0;
            den_q  <= '0;
            quo_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            rem_q  <= rem_d;
            den_q  <= den_d;
            quo_q  <= quo_d;
        end
    end

endmodule

// File: rtl/oflow_iou_engine.sv
// Handshaked IoU engine: intersection/area stage, union stage with degenerate
// exits, then an iterative divider yielding a Q1.FRAC_W score in [0, 1].
module oflow_iou_engine
    import oflow_iou_pkg::*;
#(
    parameter int COORD_W = COORD_W_DEF,
    parameter int FRAC_W  = FRAC_W_DEF,
    parameter int ID_W    = 8
) (
    input  logic                 clk,
    input  logic                 reset_N,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ID_W-1:0]      in_id,
    input  logic [4*COORD_W-1:0] bbox_position_frame_k,
    input  logic [4*COORD_W-1:0] bbox_position_frame_history,
    input  logic [COORD_W-1:0]   bbox_w_frame_k,
    input  logic [COORD_W-1:0]   bbox_h_frame_k,
    input  logic [COORD_W-1:0]   bbox_w_frame_history,
    input  logic [COORD_W-1:0]   bbox_h_frame_history,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [FRAC_W:0]      iou,
    output logic [ID_W-1:0]      out_id
);

    localparam int AW = 2 * COORD_W;
    localparam int BW = 4 * COORD_W;

    iou_state_t           state_q, state_d;
    logic [BW-1:0]        box_k_q, box_k_d, box_h_q, box_h_d;
    logic [COORD_W-1:0]   w_k_q, w_k_d, h_k_q, h_k_d;
    logic [COORD_W-1:0]   w_h_q, w_h_d, h_h_q, h_h_d;
    logic [ID_W-1:0]      id_q, id_d;
    logic [AW-1:0]        inter_q, inter_d, area_k_q, area_k_d, area_h_q, area_h_d;
    logic [FRAC_W:0]      iou_q, iou_d;

    logic [COORD_W-1:0]   ix, iy;
    logic [AW+1:0]        area_sum, union_wide;
    logic                 union_zero, union_clamp;
    logic                 div_start, div_busy, div_done;
    logic [FRAC_W-1:0]    div_quot;

    // idx: 0 = X_TL, 1 = Y_TL, 2 = X_BR, 3 = Y_BR
    function automatic logic [COORD_W-1:0] coord(input logic [BW-1:0] box, input int idx);
        return box[BW-1-idx*COORD_W -: COORD_W];
    endfunction

    // Exclusive overlap on one axis; touching or inverted boxes give 0.
    function automatic logic [COORD_W-1:0] span(
        input logic [COORD_W-1:0] tl_a, input logic [COORD_W-1:0] tl_b,
        input logic [COORD_W-1:0] br_a, input logic [COORD_W-1:0] br_b
    );
        logic [COORD_W-1:0] lo, hi;
        logic [COORD_W:0]   diff;
        lo   = (tl_a > tl_b) ? tl_a : tl_b;
        hi   = (br_a < br_b) ? br_a : br_b;
        diff = {1'b0, hi} - {1'b0, lo};
        return diff[COORD_W] ? '0 : diff[COORD_W-1:0];
    endfunction

    assign ix = span(coord(box_k_q, 0), coord(box_h_q, 0), coord(box_k_q, 2), coord(box_h_q, 2));
    assign iy = span(coord(box_k_q, 1), coord(box_h_q, 1), coord(box_k_q, 3), coord(box_h_q, 3));

    // A negative union only arises from untrusted w/h and is folded into the clamp.
    assign area_sum    = {2'b00, area_k_q} + {2'b00, area_h_q};
    assign union_wide  = area_sum - {2'b00, inter_q};
    assign union_zero  = (union_wide == '0);
    assign union_clamp = union_wide[AW+1] || ({1'b0, inter_q} >= union_wide[AW:0]);

    oflow_iou_div #(
        .NUM_W  (AW),
        .DEN_W  (AW + 1),
        .FRAC_W (FRAC_W)
    ) u_div (
        .clk   (clk),
        .rst_n (reset_N),
        .start (div_start),
        .num   (inter_q),
        .den   (union_wide[AW:0]),
        .busy  (div_busy),
        .done  (div_done),
        .quot  (div_quot)
    );

    always_comb begin
        // NOTE: every variable gets a default before the case so no path infers a latch.
        state_d   = state_q;
        box_k_d   = box_k_q;
        box_h_d   = box_h_q;
        w_k_d     = w_k_q;
        h_k_d     = h_k_q;
        w_h_d     = w_h_q;
        h_h_d     = h_h_q;
        id_d      = id_q;
        inter_d   = inter_q;
        area_k_d  = area_k_q;
        area_h_d  = area_h_q;
        iou_d     = iou_q;
        div_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    box_k_d = bbox_position_frame_k;
                    box_h_d = bbox_position_frame_history;
                    w_k_d   = bbox_w_frame_k;
                    h_k_d   = bbox_h_frame_k;
                    w_h_d   = bbox_w_frame_history;
                    h_h_d   = bbox_h_frame_history;
                    id_d    = in_id;
                    state_d = INTER;
                end
            end
            INTER: begin
                inter_d  = AW'(ix) * AW'(iy);
                area_k_d = AW'(w_k_q) * AW'(h_k_q);
                area_h_d = AW'(w_h_q) * AW'(h_h_q);
                state_d  = UNION;
            end
            UNION: begin
                if (union_zero) begin
                    iou_d   = '0;
                    state_d = DONE;
                end else if (union_clamp) begin
                    iou_d   = {1'b1, {FRAC_W{1'b0}}};
                    state_d = DONE;
                end else begin
                    div_start = 1'b1;
                    state_d   = DIV;
                end
            end
            DIV: begin
                if (div_done || !div_busy) begin
                    iou_d   = {1'b0, div_quot};
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so all flops sample together.
    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            state_q  <= IDLE;
            box_k_q  <= '0;
            box_h_q  <= '0;
            w_k_q    <= '0;
            h_k_q    <= '0;
            w_h_q    <= '0;
            h_h_q    <= '0;
            id_q     <= '0;
            inter_q  <= '0;
            area_k_q <= '0;
            area_h_q <= '0;
            iou_q    <= '0;
        end else begin
            state_q  <= state_d;
            box_k_q  <= box_k_d;
            box_h_q  <= box_h_d;
            w_k_q    <= w_k_d;
            h_k_q    <= h_k_d;
            w_h_q    <= w_h_d;
            h_h_q    <= h_h_d;
            id_q     <= id_d;
            inter_q  <= inter_d;
            area_k_q <= area_k_d;
            area_h_q <= area_h_d;
            iou_q    <= iou_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign iou       = iou_q;
    assign out_id    = id_q;

endmodule

// File: tb/tb_oflow_iou_engine.sv
// Self-checking bench for oflow_iou_engine: directed cases from the box geometry,
// backpressure, mid-operation reset and randomized pairs against a behavioural model.
module tb_oflow_iou_engine;
    import oflow_iou_pkg::*;

    localparam int C  = COORD_W_DEF;
    localparam int FW = FRAC_W_DEF;

    logic           clk = 1'b0;
    logic           reset_N = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [7:0]     in_id = '0;
    logic [4*C-1:0] bk = '0, bh = '0;
    logic [C-1:0]   wk = '0, hk = '0, wh = '0, hh = '0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [FW:0]    iou;
    logic [7:0]     out_id;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int mode = 0;      // out_ready: 0 always high, 1 random, 2 held low
    int xfer_cyc = 0;

    typedef struct {
        int iou;
        int id;
        int lat;
        int acc;
    } exp_t;
    exp_t pend[$];

    oflow_iou_engine dut (
        .clk                         (clk),
        .reset_N                     (reset_N),
        .in_valid                    (in_valid),
        .in_ready                    (in_ready),
        .in_id                       (in_id),
        .bbox_position_frame_k       (bk),
        .bbox_position_frame_history (bh),
        .bbox_w_frame_k              (wk),
        .bbox_h_frame_k              (hk),
        .bbox_w_frame_history        (wh),
        .bbox_h_frame_history        (hh),
        .out_valid                   (out_valid),
        .out_ready                   (out_ready),
        .iou                         (iou),
        .out_id                      (out_id)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // IoU straight from the geometry; lat counts the accept cycle as cycle 0.
    function automatic void model(input logic [4*C-1:0] pk, input logic [4*C-1:0] ph,
                                  input logic [C-1:0] w_k, input logic [C-1:0] h_k,
                                  input logic [C-1:0] w_h, input logic [C-1:0] h_h,
                                  output int m_iou, output int m_lat);
        bbox_t a, b;
        longint lo, hi, ix, iy, inter, uni;
        a = bbox_unpack(pk);
        b = bbox_unpack(ph);
        lo = (a.x_tl > b.x_tl) ? a.x_tl : b.x_tl;
        hi = (a.x_br < b.x_br) ? a.x_br : b.x_br;
        ix = (hi > lo) ? hi - lo : 0;
        lo = (a.y_tl > b.y_tl) ? a.y_tl : b.y_tl;
        hi = (a.y_br < b.y_br) ? a.y_br : b.y_br;
        iy = (hi > lo) ? hi - lo : 0;
        inter = ix * iy;
        uni = longint'(w_k) * h_k + longint'(w_h) * h_h - inter;
        if (uni == 0) begin
            m_iou = 0; m_lat = 3;
        end else if (inter >= uni) begin
            m_iou = 1 << FW; m_lat = 3;
        end else begin
            m_iou = int'((inter << FW) / uni); m_lat = FW + 3;
        end
    endfunction

    initial forever begin
        @(negedge clk);
        out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    // Per-cycle compare against the model; also owns the in-flight expectation queue.
    initial forever begin
        exp_t e;
        int m_iou, m_lat;
        bit exp_ready, exp_valid;
        @(negedge clk);
        #2;
        if (!reset_N) begin
            pend.delete();
            check("rst_in_ready", in_ready, 1);
            check("rst_out_valid", out_valid, 0);
            check("rst_iou", iou, 0);
            check("rst_out_id", out_id, 0);
        end else begin
            exp_ready = (pend.size() == 0);
            check("in_ready", in_ready, exp_ready);
            if (pend.size() == 0) begin
                check("out_valid_idle", out_valid, 0);
            end else begin
                e = pend[0];
                exp_valid = (cyc - e.acc + 1) >= e.lat;
                check("out_valid", out_valid, exp_valid);
                if (out_valid && exp_valid) begin
                    check("iou", iou, e.iou);
                    check("out_id", out_id, e.id);
                end
                if (out_valid && out_ready) begin
                    void'(pend.pop_front());
                    xfer_cyc = cyc + 1;
                end
            end
            if (exp_ready && in_valid) begin
                model(bk, bh, wk, hk, wh, hh, m_iou, m_lat);
                pend.push_back('{iou: m_iou, id: int'(in_id), lat: m_lat, acc: cyc + 1});
            end
        end
    end

    task automatic send(input logic [4*C-1:0] pk, input logic [4*C-1:0] ph,
                        input logic [C-1:0] w_k, input logic [C-1:0] h_k,
                        input logic [C-1:0] w_h, input logic [C-1:0] h_h,
                        input logic [7:0] id, output int acc);
        int k = 0;
        @(negedge clk);
        bk = pk; bh = ph; wk = w_k; hk = h_k; wh = w_h; hh = h_h; in_id = id;
        in_valid = 1'b1;
        #1;
        while (!in_ready && k < 200) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (!in_ready) check("accept_timeout", 0, 1);
        @(posedge clk);
        @(negedge clk);
        acc = cyc;
        in_valid = 1'b0;
        // Scramble the now-idle inputs; the engine must hold its sampled copy.
        bk = {$urandom, $urandom}; bh = {$urandom, $urandom};
        wk = C'($urandom); hk = C'($urandom); in_id = 8'($urandom);
    endtask

    task automatic wait_valid(input string name);
        int k = 0;
        #3;
        while (!out_valid && k < 64) begin
            @(negedge clk);
            #3;
            k++;
        end
        if (!out_valid) check({name, "_timeout"}, 0, 1);
    endtask

    task automatic run_one(input string name, input logic [4*C-1:0] pk, input logic [4*C-1:0] ph,
                           input logic [C-1:0] w_k, input logic [C-1:0] h_k,
                           input logic [C-1:0] w_h, input logic [C-1:0] h_h,
                           input logic [7:0] id, input int exp_iou, input int exp_lat);
        int acc;
        send(pk, ph, w_k, h_k, w_h, h_h, id, acc);
        wait_valid(name);
        check({name, "_iou"}, iou, exp_iou);
        check({name, "_lat"}, cyc - acc + 1, exp_lat);
        @(negedge clk);
    endtask

    task automatic rand_box(output logic [4*C-1:0] p, output logic [C-1:0] w, output logic [C-1:0] h);
        int xt, yt, xb, yb, t;
        xt = $urandom_range(0, 120);
        yt = $urandom_range(0, 120);
        xb = xt + $urandom_range(0, 80);
        yb = yt + $urandom_range(0, 80);
        if ($urandom_range(0, 9) == 0) begin
            t = xt; xt = xb; xb = t;
        end
        p = {C'(xt), C'(yt), C'(xb), C'(yb)};
        w = (xb > xt) ? C'(xb - xt) : '0;
        h = C'(yb - yt);
        if ($urandom_range(0, 7) == 0) w = C'($urandom);
        if ($urandom_range(0, 15) == 0) begin
            w = '0; h = '0;
        end
    endtask

    localparam logic [4*C-1:0] OV_K = {11'd0, 11'd0, 11'd10, 11'd10};
    localparam logic [4*C-1:0] OV_H = {11'd5, 11'd5, 11'd15, 11'd15};

    initial begin
        int m_iou, m_lat, acc;
        logic [4*C-1:0] rk, rh;
        logic [C-1:0]   rwk, rhk, rwh, rhh;

        #1 reset_N = 1'b0;
        repeat (3) @(negedge clk);
        reset_N = 1'b1;

        model(OV_K, OV_H, 10, 10, 10, 10, m_iou, m_lat);
        check("model_overlap", m_iou, 292);
        model({11'd100, 11'd100, 11'd140, 11'd120}, {11'd100, 11'd100, 11'd140, 11'd120},
              40, 20, 40, 20, m_iou, m_lat);
        check("model_identical", m_iou, 2048);
        check("model_identical_lat", m_lat, 3);

        run_one("overlap", OV_K, OV_H, 10, 10, 10, 10, 8'h01, 292, 14);
        run_one("disjoint", {11'd500, 11'd250, 11'd520, 11'd280},
                {11'd1000, 11'd1200, 11'd1010, 11'd1215}, 20, 30, 10, 15, 8'h02, 0, 14);
        run_one("identical", {11'd100, 11'd100, 11'd140, 11'd120},
                {11'd100, 11'd100, 11'd140, 11'd120}, 40, 20, 40, 20, 8'h03, 2048, 3);
        run_one("all_zero", '0, '0, 0, 0, 0, 0, 8'h04, 0, 3);
        run_one("inverted", {11'd50, 11'd50, 11'd40, 11'd60},
                {11'd30, 11'd50, 11'd60, 11'd60}, 10, 10, 30, 10, 8'h05, 0, 14);
        run_one("touching", {11'd0, 11'd0, 11'd10, 11'd10},
                {11'd10, 11'd0, 11'd20, 11'd10}, 10, 10, 10, 10, 8'h06, 0, 14);

        // Backpressure, then a back-to-back pair right after the output transfer.
        mode = 2;
        send(OV_K, OV_H, 10, 10, 10, 10, 8'h3A, acc);
        wait_valid("bp");
        repeat (5) begin
            @(negedge clk);
            #3;
            check("bp_valid", out_valid, 1);
            check("bp_iou", iou, 292);
            check("bp_id", out_id, 8'h3A);
            check("bp_in_ready", in_ready, 0);
        end
        mode = 0;
        send(OV_K, OV_H, 10, 10, 10, 10, 8'h3B, acc);
        check("b2b_gap", acc - xfer_cyc, 1);
        wait_valid("b2b");
        check("b2b_iou", iou, 292);
        check("b2b_id", out_id, 8'h3B);
        @(negedge clk);

        // Reset while the divider is iterating.
        send(OV_K, OV_H, 10, 10, 10, 10, 8'h77, acc);
        repeat (6) @(negedge clk);
        reset_N = 1'b0;
        repeat (2) @(negedge clk);
        reset_N = 1'b1;
        #3;
        check("post_rst_valid", out_valid, 0);
        check("post_rst_iou", iou, 0);
        check("post_rst_ready", in_ready, 1);
        repeat (20) @(negedge clk);
        run_one("after_reset", OV_K, OV_H, 10, 10, 10, 10, 8'h12, 292, 14);

        mode = 1;
        for (int i = 0; i < 60; i++) begin
            rand_box(rk, rwk, rhk);
            rand_box(rh, rwh, rhh);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send(rk, rh, rwk, rhk, rwh, rhh, 8'($urandom), acc);
        end
        for (int k = 0; k < 200 && pend.size() != 0; k++) @(negedge clk);
        check("drain", pend.size(), 0);
        mode = 0;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/oflow_iou_engine.md
# oflow_iou_engine

Parametrised, handshaked IoU engine for the optical-flow tracker. It scores one bounding box from frame k against one box from the history frame and returns an unsigned fixed-point IoU in [0, 1]. A multi-cycle pipeline computes the intersection and union, followed by an iterative divider. It replaces the combinational IoU calculator and feeds the matching and scoring stage that pairs current detections with tracked objects.

## Interface
Parameters:
- COORD_W, 11, width of each coordinate and of w/h.
- FRAC_W, 11, fractional bits of IoU; result is Q1.FRAC_W.
- ID_W, 8, width of the pass-through pair tag.

Ports:
- clk  in  1  clock; single clock domain.
- reset_N  in  1  asynchronous, active-low reset.
- in_valid  in  1  input pair valid.
- in_ready  out  1  engine can accept; high only in IDLE.
- in_id  in  ID_W  tag carried to the output.
- bbox_position_frame_k  in  4*COORD_W  {X_TL, Y_TL, X_BR, Y_BR}, unsigned.
- bbox_position_frame_history  in  4*COORD_W  same packing.
- bbox_w_frame_k, bbox_h_frame_k  in  COORD_W  frame-k box width/height.
- bbox_w_frame_history, bbox_h_frame_history  in  COORD_W  history box width/height.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer accepts the result.
- iou  out  FRAC_W+1  floor(inter*2^FRAC_W/union); 2^FRAC_W represents 1.0.
- out_id  out  ID_W  tag of the pair.

## Operation
- Handshake: an input transfer occurs on in_valid & in_ready. An output transfer occurs on out_valid & out_ready. Inputs are sampled only at transfer.
- FSM states: IDLE, INTER, UNION, DIV, DONE.
  - IDLE: on input transfer, register all inputs, go to INTER.
  - INTER: compute ix = max(0, min(XBR_k,XBR_h) - max(XTL_k,XTL_h)) and iy likewise. Register inter = ix*iy (2*COORD_W bits), area_k = w_k*h_k and area_h = w_h*h_h. Go to UNION.
  - UNION: union = area_k + area_h - inter, computed in 2*COORD_W+1 bits. Exit depends on the values:
    - If union == 0: iou = 0, go to DONE.
    - Else if inter >= union: iou = 2^FRAC_W (clamp), go to DONE.
    - Else: rem = inter, cnt = FRAC_W, go to DIV.
  - DIV: each cycle, rem = rem<<1; if rem >= union, subtract union and shift in 1, else shift in 0. Decrement cnt. At cnt == 1, write the quotient to iou and go to DONE.
  - DONE: out_valid = 1. On out_ready, go to IDLE.
- Intersection coordinates are exclusive: touching edges give ix = 0. If BR < TL on an axis, ix or iy is clamped to 0.
- The w/h inputs are trusted for area and are not cross-checked against the coordinates. The inter >= union clamp covers inconsistent inputs.
- Subtractions are performed 1 bit wider than the operands and never wrap.

## Timing
- Reset values: state IDLE, in_ready 1, out_valid 0, iou 0, out_id 0, all internal registers 0.
- Latency from the input-transfer edge to out_valid high:
  - normal path: FRAC_W+3 cycles (14 at default);
  - union == 0 or clamp path: 3 cycles.
- Throughput: one pair per latency + 1 cycles minimum. in_ready is low from the edge after acceptance until the cycle after the output transfer.
- in_ready depends only on state, with no combinational path from out_ready.
- While out_valid is high and out_ready is low, iou and out_id are stable.
- Reset asserted mid-operation returns every state and output to its reset value immediately. The in-flight pair is dropped and produces no output.

## Structure
- Shared package oflow_iou_pkg holds:
  - state enum iou_state_t {IDLE, INTER, UNION, DIV, DONE};
  - default localparams COORD_W_DEF = 11, FRAC_W_DEF = 11;
  - a bbox struct-unpack function for {X_TL, Y_TL, X_BR, Y_BR}.
- The sub-module oflow_iou_div is the sequential restoring divider. It has a start/busy/done interface and is parametrised by dividend/divisor width and FRAC_W. The top level owns the FSM, the handshake, the area math and the degenerate-case exits.

## Test plan
- Overlap: k TL(0,0) BR(10,10) w=h=10; hist TL(5,5) BR(15,15) w=h=10 → inter 25, union 175, iou = 292, out_valid 14 cycles after accept.
- Disjoint: k {500,250,520,280} w=20 h=30; hist {1000,1200,1010,1215} w=10 h=15 → inter 0, union 750, iou = 0 after 14 cycles.
- Identical boxes: both {100,100,140,120} w=40 h=20 → clamp, iou = 2048 after 3 cycles.
- All-zero inputs → union 0, iou = 0 after 3 cycles. Also a degenerate BR < TL case → ix = 0.
- Backpressure: hold out_ready low 5 cycles after out_valid → iou and out_id stable, in_ready 0, then output accepted. A back-to-back second pair is accepted 1 cycle after the transfer, with in_id tags 0x3A then 0x3B preserved.
- Reset pulse during DIV (cycle 6 after accept) → out_valid 0, iou 0, in_ready 1 at release, no stray output. A subsequent overlap pair still gives iou = 292.
